// File: rtl/line_mem_pkg.sv
// rtl/line_mem_pkg.sv - shared types and constants for the line memory arbiter
package line_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Saturating event counter step used by the optional performance counters
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/line_mem_arbiter_rr_arb2.sv
// rtl/line_mem_arbiter_rr_arb2.sv - two-way round-robin pick
// On a tie the port that did not win last time is chosen.
module rr_arb2
  import line_mem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      grant = (last_grant == PORT_I) ? PORT_D : PORT_I;
    end else begin
      grant = req1 ? PORT_D : PORT_I;
    end
  end

endmodule

// File: rtl/line_mem_arbiter.sv
// rtl/line_mem_arbiter.sv - round-robin share of one line-wide memory port between two caches
// Optional grant/wait counters are built when ARB_PERF_CNT_EN is defined.
module line_mem_arbiter
  import line_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  p0_r,
  input  logic                  p0_w,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [LINE_WIDTH-1:0] p0_w_data,
  output logic [LINE_WIDTH-1:0] p0_r_data,
  output logic                  p0_ready,
  input  logic                  p1_r,
  input  logic                  p1_w,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [LINE_WIDTH-1:0] p1_w_data,
  output logic [LINE_WIDTH-1:0] p1_r_data,
  output logic                  p1_ready,
  output logic                  m_r,
  output logic                  m_w,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [LINE_WIDTH-1:0] m_w_data,
  input  logic [LINE_WIDTH-1:0] m_r_data,
  input  logic                  m_ready
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]           p0_grant_cnt,
  output logic [31:0]           p1_grant_cnt,
  output logic [31:0]           p0_wait_cnt,
  output logic [31:0]           p1_wait_cnt
`endif
);

  state_e                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    last_grant_q, last_grant_d;
  op_e                     op_q, op_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;

  logic p0_req, p1_req;
  logic arb_valid, arb_grant;
  logic busy;
  logic grant_evt;

  assign p0_req = p0_r | p0_w;
  assign p1_req = p1_r | p1_w;
  assign busy   = (state_q == BUSY);

  rr_arb2 u_rr_arb2 (
    .req0       (p0_req),
    .req1       (p1_req),
    .last_grant (last_grant_q),
    .valid      (arb_valid),
    .grant      (arb_grant)
  );

  assign grant_evt = (state_q == IDLE) && arb_valid;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = BUSY;
          grant_d = arb_grant;
          // Write takes precedence when a port raises r and w together
          if (arb_grant == PORT_D) begin
            op_d    = p1_w ? OP_WRITE : OP_READ;
            addr_d  = p1_addr;
            wdata_d = p1_w_data;
          end else begin
            op_d    = p0_w ? OP_WRITE : OP_READ;
            addr_d  = p0_addr;
            wdata_d = p0_w_data;
          end
        end
      end
      BUSY: begin
        if (m_ready) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_q      <= PORT_I;
      last_grant_q <= PORT_D;
      op_q         <= OP_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Downstream request comes only from the latch, so upstream changes after grant are invisible
  assign m_r      = busy && (op_q == OP_READ);
  assign m_w      = busy && (op_q == OP_WRITE);
  assign m_addr   = addr_q;
  assign m_w_data = wdata_q;

  assign p0_ready  = busy && m_ready && (grant_q == PORT_I);
  assign p1_ready  = busy && m_ready && (grant_q == PORT_D);
  assign p0_r_data = m_r_data;
  assign p1_r_data = m_r_data;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] p0_grant_cnt_q, p0_grant_cnt_d;
  logic [31:0] p1_grant_cnt_q, p1_grant_cnt_d;
  logic [31:0] p0_wait_cnt_q, p0_wait_cnt_d;
  logic [31:0] p1_wait_cnt_q, p1_wait_cnt_d;

  always_comb begin
    p0_grant_cnt_d = sat_inc(p0_grant_cnt_q, grant_evt && (arb_grant == PORT_I));
    p1_grant_cnt_d = sat_inc(p1_grant_cnt_q, grant_evt && (arb_grant == PORT_D));
    p0_wait_cnt_d  = sat_inc(p0_wait_cnt_q, p0_req && !(busy && (grant_q == PORT_I)));
    p1_wait_cnt_d  = sat_inc(p1_wait_cnt_q, p1_req && !(busy && (grant_q == PORT_D)));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p0_grant_cnt_q <= '0;
      p1_grant_cnt_q <= '0;
      p0_wait_cnt_q  <= '0;
      p1_wait_cnt_q  <= '0;
    end else begin
      p0_grant_cnt_q <= p0_grant_cnt_d;
      p1_grant_cnt_q <= p1_grant_cnt_d;
      p0_wait_cnt_q  <= p0_wait_cnt_d;
      p1_wait_cnt_q  <= p1_wait_cnt_d;
    end
  end

  assign p0_grant_cnt = p0_grant_cnt_q;
  assign p1_grant_cnt = p1_grant_cnt_q;
  assign p0_wait_cnt  = p0_wait_cnt_q;
  assign p1_wait_cnt  = p1_wait_cnt_q;
`else
  logic unused_grant_evt;
  assign unused_grant_evt = grant_evt;
`endif

endmodule

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
- Two-port arbiter sharing one line-wide main-memory port between two write-back caches (port 0 = instruction cache, port 1 = data cache).
- Each upstream port uses the cache-side memory protocol: level-held r/w request, 128-bit line data, one-cycle ready pulse.
- Arbitrates round-robin, latches the winning request, drives it downstream, and routes the completion pulse back to the winner only.
- Sits between the cache pair and the main-memory model.

Parameters:
ADDR_WIDTH, 32, byte address width on all ports
LINE_WIDTH, 128, cache line width in bits (data bus width on all ports)

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-low
p0_r  in  1  port 0 line read request, held high until p0_ready
p0_w  in  1  port 0 line write request, held high until p0_ready
p0_addr  in  ADDR_WIDTH  port 0 line address
p0_w_data  in  LINE_WIDTH  port 0 write line
p0_r_data  out  LINE_WIDTH  port 0 read line, valid when p0_ready
p0_ready  out  1  port 0 completion pulse
p1_r, p1_w, p1_addr, p1_w_data, p1_r_data, p1_ready  -  same as port 0, for port 1
m_r  out  1  memory read request
m_w  out  1  memory write request
m_addr  out  ADDR_WIDTH  memory address
m_w_data  out  LINE_WIDTH  memory write line
m_r_data  in  LINE_WIDTH  memory read line
m_ready  in  1  memory completion pulse

Behaviour:
- Reset (async, rstn=0):
  - State IDLE; m_r=m_w=0; m_addr=0; m_w_data=0; p*_ready=0.
  - last_grant=1, so port 0 wins the first tie.
  - A reset mid-transaction abandons the transaction; no ready pulse is produced.
- States:
  - IDLE: if any port requests (r|w), choose the winner and latch addr, w_data, op (write if w, else read) and the grant index; go to BUSY. Otherwise stay in IDLE.
  - BUSY: m_r/m_w/m_addr/m_w_data are driven from the latch registers, not from upstream inputs. On m_ready=1: set last_grant=grant, go to IDLE.
- Arbitration:
  - Only one port requesting: it wins.
  - Both requesting: the port not equal to last_grant wins, so each port waits for at most one foreign transaction.
- Op precedence: if a port asserts r and w together, write wins.
- Latency:
  - The downstream request appears the cycle after the upstream request is first seen in IDLE.
  - The minimum upstream-to-ready time is 2 cycles plus memory latency.
- Response path:
  - p<g>_ready = (state==BUSY) & m_ready & (grant==g). This is combinational, same cycle as m_ready.
  - p0_r_data and p1_r_data both equal m_r_data. The data is only meaningful with the matching ready.
  - The non-granted port's ready stays 0.
- Release:
  - The upstream port drops its request in the ready cycle.
  - The arbiter is back in IDLE the next cycle and re-arbitrates from the requests sampled there.
  - A cache doing write-back then refill therefore re-requests and competes again under round-robin.
- Withdrawal:
  - Before grant: allowed, no effect.
  - After grant: illegal. The arbiter still completes the latched transaction and pulses ready.
- m_ready while IDLE: ignored.
- m_r and m_w are never both 1.

Optional Feature:
ARB_PERF_CNT_EN
- Defined: adds output ports p0_grant_cnt, p1_grant_cnt, p0_wait_cnt, p1_wait_cnt, each 32 bits, all reset to 0, all saturating at 32'hFFFFFFFF.
  - grant_cnt increments on each IDLE->BUSY grant to that port.
  - wait_cnt increments each cycle the port requests and is not the BUSY grantee. This includes the cycle its request is sampled in IDLE.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package line_mem_pkg:
  - state enum (IDLE, BUSY);
  - op encoding (OP_READ=0, OP_WRITE=1);
  - port index constants (PORT_I=0, PORT_D=1).
- Optional sub-module rr_arb2: two-way round-robin pick from (req0, req1, last_grant) producing (valid, grant). It is combinational and used in IDLE.

Test Plan:
1. Port 0 reads 32'h0000_0040 alone; memory returns 128'hA5A5...A5 after 3 cycles.
   -> m_r=1 with m_addr=32'h40 from cycle 1; p0_ready pulses exactly once with p0_r_data=128'hA5...A5; p1_ready stays 0.
2. Both ports request in the same cycle after reset (p0 read 32'h100, p1 write 32'h200 with data 128'h1234).
   -> p0 is served first, then p1 with m_w=1, m_addr=32'h200, m_w_data=128'h1234.
   -> On the next simultaneous request, p1 does not win twice in a row.
3. Port 1 does write-back (32'h300) then refill (32'h340) while port 0 holds a read of 32'h500.
   -> Order is p1 write, p0 read, p1 read.
4. Port 1 asserts r and w together at 32'h80.
   -> Memory sees a write only (m_w=1, m_r=0).
5. rstn pulled low in BUSY with m_ready never arriving.
   -> All outputs are 0 immediately.
   -> After release, a fresh port 0 request is granted normally and no stale ready is seen.
6. With ARB_PERF_CNT_EN defined, run scenario 2.
   -> p0_grant_cnt=1, p1_grant_cnt=1, and p1_wait_cnt equals the cycles p1 requested without being the BUSY grantee (including its IDLE sampling cycle).
